// File: rtl/cycle_sequencer.sv
// Instruction register and machine-cycle sequencer: latches opcodes, decodes the
// one-hot X/Y/Z/P/Q fields, runs T-state/M-cycle counters and handles the 0xCB prefix.
module cycle_sequencer (
    input  logic       i_Clk,
    input  logic       i_Reset_n,
    input  logic       i_Enable,
    input  logic [7:0] i_Bus_Data,
    input  logic       i_Fetch,
    output logic [7:0] o_Opcode,
    output logic [3:0] o_X,
    output logic [7:0] o_Y,
    output logic [7:0] o_Z,
    output logic [3:0] o_P,
    output logic [1:0] o_Q,
    output logic [3:0] o_Cycle_Step,
    output logic [7:0] o_Cycle_Count,
    output logic       o_CB_Prefix,
    output logic       o_Decode_Valid,
    output logic       o_Prefix_Fetch,
    output logic       o_Sequence_Error
);

    typedef enum logic [3:0] {
        T1 = 4'b0001,
        T2 = 4'b0010,
        T3 = 4'b0100,
        T4 = 4'b1000
    } t_state_e;

    t_state_e   step_q, step_d;
    logic [7:0] ir_q, ir_d;
    logic [7:0] count_q, count_d;
    logic       cb_q, cb_d;
    logic       err_q, err_d;
    logic       decode_valid;
    logic       prefix_fetch;

    // An unprefixed 0xCB in IR means the next M-cycle fetches the second byte
    // itself; the prefix-fetch flag is therefore a pure function of IR state.
    assign decode_valid = !((ir_q == 8'hCB) && !cb_q);
    assign prefix_fetch = !decode_valid;

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            step_q  <= T1;
            ir_q    <= '0;
            count_q <= 8'h01;
            cb_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            step_q  <= step_d;
            ir_q    <= ir_d;
            count_q <= count_d;
            cb_q    <= cb_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        step_d  = step_q;
        ir_d    = ir_q;
        count_d = count_q;
        cb_d    = cb_q;
        err_d   = err_q;
        if (i_Enable) begin
            case (step_q)
                T1:      step_d = T2;
                T2:      step_d = T3;
                T3:      step_d = T4;
                T4:      step_d = T1;
                default: step_d = T1;
            endcase
            if (step_q == T4) begin
                if ((i_Fetch && decode_valid) || prefix_fetch) begin
                    ir_d    = i_Bus_Data;
                    count_d = 8'h01;
                    cb_d    = prefix_fetch;
                end else if (count_q[7]) begin
                    err_d = 1'b1;
                end else begin
                    count_d = count_q << 1;
                end
            end
        end
    end

    assign o_Opcode         = ir_q;
    assign o_X              = 4'(1) << ir_q[7:6];
    assign o_Y              = 8'(1) << ir_q[5:3];
    assign o_Z              = 8'(1) << ir_q[2:0];
    assign o_P              = 4'(1) << ir_q[5:4];
    assign o_Q              = 2'(1) << ir_q[3];
    assign o_Cycle_Step     = step_q;
    assign o_Cycle_Count    = count_q;
    assign o_CB_Prefix      = cb_q;
    assign o_Decode_Valid   = decode_valid;
    assign o_Prefix_Fetch   = prefix_fetch;
    assign o_Sequence_Error = err_q;

endmodule

// File: tb/tb_cycle_sequencer.sv
// Directed self-checking bench for cycle_sequencer.
module tb_cycle_sequencer;

    logic       i_Clk = 1'b0;
    logic       i_Reset_n = 1'b0;
    logic       i_Enable = 1'b1;
    logic [7:0] i_Bus_Data = 8'h00;
    logic       i_Fetch = 1'b0;
    logic [7:0] o_Opcode;
    logic [3:0] o_X;
    logic [7:0] o_Y;
    logic [7:0] o_Z;
    logic [3:0] o_P;
    logic [1:0] o_Q;
    logic [3:0] o_Cycle_Step;
    logic [7:0] o_Cycle_Count;
    logic       o_CB_Prefix;
    logic       o_Decode_Valid;
    logic       o_Prefix_Fetch;
    logic       o_Sequence_Error;

    int checks = 0;
    int failures = 0;

    // fld = {IR, X, Y, Z, P, Q}; sts = {step, count, cb, decode_valid, prefix_fetch, error}
    logic [33:0] fld;
    logic [15:0] sts;
    localparam logic [33:0] NOP_FLD = {8'h00, 4'b0001, 8'h01, 8'h01, 4'b0001, 2'b01};
    localparam logic [15:0] RST_STS = {4'b0001, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0};

    assign fld = {o_Opcode, o_X, o_Y, o_Z, o_P, o_Q};
    assign sts = {o_Cycle_Step, o_Cycle_Count, o_CB_Prefix, o_Decode_Valid,
                  o_Prefix_Fetch, o_Sequence_Error};

    cycle_sequencer dut (
        .i_Clk            (i_Clk),
        .i_Reset_n        (i_Reset_n),
        .i_Enable         (i_Enable),
        .i_Bus_Data       (i_Bus_Data),
        .i_Fetch          (i_Fetch),
        .o_Opcode         (o_Opcode),
        .o_X              (o_X),
        .o_Y              (o_Y),
        .o_Z              (o_Z),
        .o_P              (o_P),
        .o_Q              (o_Q),
        .o_Cycle_Step     (o_Cycle_Step),
        .o_Cycle_Count    (o_Cycle_Count),
        .o_CB_Prefix      (o_CB_Prefix),
        .o_Decode_Valid   (o_Decode_Valid),
        .o_Prefix_Fetch   (o_Prefix_Fetch),
        .o_Sequence_Error (o_Sequence_Error)
    );

    always #5 i_Clk = ~i_Clk;

    task automatic clk_n(input int n);
        repeat (n) begin
            @(posedge i_Clk);
            #1;
        end
    endtask

    task automatic test_reset();
        clk_n(2);
        checks++;
        if (fld !== NOP_FLD) begin
            failures++;
            $display("FAIL reset_fields got=%h exp=%h", fld, NOP_FLD);
        end
        checks++;
        if (sts !== RST_STS) begin
            failures++;
            $display("FAIL reset_status got=%h exp=%h", sts, RST_STS);
        end
        i_Reset_n = 1'b1;
        checks++;
        if (sts !== RST_STS) begin
            failures++;
            $display("FAIL reset_release got=%h exp=%h", sts, RST_STS);
        end
        clk_n(4);
        checks++;
        if (sts !== {4'b0001, 8'h02, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_first_mcycle got=%h exp=%h", sts,
                     {4'b0001, 8'h02, 1'b0, 1'b1, 1'b0, 1'b0});
        end
    endtask

    task automatic test_fetch();
        clk_n(3);
        i_Fetch = 1'b1;
        i_Bus_Data = 8'hC9;
        clk_n(1);
        i_Fetch = 1'b0;
        i_Bus_Data = 8'h00;
        checks++;
        if (fld !== {8'hC9, 4'b1000, 8'h02, 8'h02, 4'b0001, 2'b10}) begin
            failures++;
            $display("FAIL fetch_c9_fields got=%h exp=%h", fld,
                     {8'hC9, 4'b1000, 8'h02, 8'h02, 4'b0001, 2'b10});
        end
        checks++;
        if (sts !== RST_STS) begin
            failures++;
            $display("FAIL fetch_c9_status got=%h exp=%h", sts, RST_STS);
        end
    endtask

    task automatic test_early_fetch();
        i_Fetch = 1'b1;
        i_Bus_Data = 8'h11;
        clk_n(3);
        i_Fetch = 1'b0;
        clk_n(1);
        checks++;
        if ({o_Opcode, o_Cycle_Step, o_Cycle_Count} !== {8'hC9, 4'b0001, 8'h02}) begin
            failures++;
            $display("FAIL early_fetch_ignored got=%h exp=%h",
                     {o_Opcode, o_Cycle_Step, o_Cycle_Count}, {8'hC9, 4'b0001, 8'h02});
        end
    endtask

    task automatic test_cb_prefix();
        logic [3:0] e_step;
        clk_n(3);
        i_Fetch = 1'b1;
        i_Bus_Data = 8'hCB;
        clk_n(1);
        for (int i = 0; i < 4; i++) begin
            e_step = 4'(1 << i);
            checks++;
            if (sts !== {e_step, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0}) begin
                failures++;
                $display("FAIL prefix_cycle_t%0d got=%h exp=%h", i + 1, sts,
                         {e_step, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0});
            end
            if (i == 3) i_Bus_Data = 8'h37;
            clk_n(1);
        end
        i_Fetch = 1'b0;
        checks++;
        if (fld !== {8'h37, 4'b0001, 8'h40, 8'h80, 4'b1000, 2'b01}) begin
            failures++;
            $display("FAIL cb37_fields got=%h exp=%h", fld,
                     {8'h37, 4'b0001, 8'h40, 8'h80, 4'b1000, 2'b01});
        end
        checks++;
        if (sts !== {4'b0001, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL cb37_status got=%h exp=%h", sts,
                     {4'b0001, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0});
        end
        clk_n(3);
        i_Fetch = 1'b1;
        i_Bus_Data = 8'h00;
        clk_n(1);
        i_Fetch = 1'b0;
        checks++;
        if ({fld, sts} !== {NOP_FLD, RST_STS}) begin
            failures++;
            $display("FAIL cb_clear got=%h exp=%h", {fld, sts}, {NOP_FLD, RST_STS});
        end
    endtask

    task automatic test_cb_table_cb();
        clk_n(3);
        i_Fetch = 1'b1;
        i_Bus_Data = 8'hCB;
        clk_n(1);
        i_Fetch = 1'b0;
        clk_n(3);
        clk_n(1);
        checks++;
        if ({fld, sts} !== {8'hCB, 4'b1000, 8'h02, 8'h08, 4'b0001, 2'b10,
                            4'b0001, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL cb_table_cb got=%h exp=%h", {fld, sts},
                     {8'hCB, 4'b1000, 8'h02, 8'h08, 4'b0001, 2'b10,
                      4'b0001, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0});
        end
        i_Bus_Data = 8'h00;
    endtask

    task automatic test_stall();
        clk_n(9);
        i_Enable = 1'b0;
        i_Fetch = 1'b1;
        clk_n(3);
        checks++;
        if ({o_Cycle_Step, o_Cycle_Count} !== {4'b0010, 8'h04}) begin
            failures++;
            $display("FAIL stall_hold got=%h exp=%h", {o_Cycle_Step, o_Cycle_Count},
                     {4'b0010, 8'h04});
        end
        i_Enable = 1'b1;
        i_Fetch = 1'b0;
        clk_n(2);
        checks++;
        if ({o_Cycle_Step, o_Cycle_Count} !== {4'b1000, 8'h04}) begin
            failures++;
            $display("FAIL stall_resume_t4 got=%h exp=%h", {o_Cycle_Step, o_Cycle_Count},
                     {4'b1000, 8'h04});
        end
        clk_n(1);
        checks++;
        if ({o_Cycle_Step, o_Cycle_Count} !== {4'b0001, 8'h08}) begin
            failures++;
            $display("FAIL stall_advance got=%h exp=%h", {o_Cycle_Step, o_Cycle_Count},
                     {4'b0001, 8'h08});
        end
    endtask

    task automatic test_saturate();
        clk_n(16);
        checks++;
        if ({o_Cycle_Count, o_Sequence_Error} !== {8'h80, 1'b0}) begin
            failures++;
            $display("FAIL count_reach_bit7 got=%h exp=%h", {o_Cycle_Count, o_Sequence_Error},
                     {8'h80, 1'b0});
        end
        clk_n(4);
        checks++;
        if ({o_Cycle_Count, o_Sequence_Error} !== {8'h80, 1'b1}) begin
            failures++;
            $display("FAIL count_overrun got=%h exp=%h", {o_Cycle_Count, o_Sequence_Error},
                     {8'h80, 1'b1});
        end
        clk_n(3);
        i_Fetch = 1'b1;
        i_Bus_Data = 8'h76;
        clk_n(1);
        i_Fetch = 1'b0;
        checks++;
        if ({fld, sts} !== {8'h76, 4'b0010, 8'h40, 8'h40, 4'b1000, 2'b01,
                            4'b0001, 8'h01, 1'b0, 1'b1, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL reload_after_error got=%h exp=%h", {fld, sts},
                     {8'h76, 4'b0010, 8'h40, 8'h40, 4'b1000, 2'b01,
                      4'b0001, 8'h01, 1'b0, 1'b1, 1'b0, 1'b1});
        end
    endtask

    task automatic test_async_reset();
        clk_n(3);
        i_Fetch = 1'b1;
        i_Bus_Data = 8'hCB;
        clk_n(1);
        clk_n(2);
        checks++;
        if (sts !== {4'b0100, 8'h01, 1'b0, 1'b0, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL prefix_t3_before_reset got=%h exp=%h", sts,
                     {4'b0100, 8'h01, 1'b0, 1'b0, 1'b1, 1'b1});
        end
        #2;
        i_Reset_n = 1'b0;
        #1;
        checks++;
        if ({fld, sts} !== {NOP_FLD, RST_STS}) begin
            failures++;
            $display("FAIL async_reset got=%h exp=%h", {fld, sts}, {NOP_FLD, RST_STS});
        end
        i_Fetch = 1'b0;
        clk_n(2);
        i_Reset_n = 1'b1;
        checks++;
        if ({fld, sts} !== {NOP_FLD, RST_STS}) begin
            failures++;
            $display("FAIL reset_held got=%h exp=%h", {fld, sts}, {NOP_FLD, RST_STS});
        end
        clk_n(4);
        checks++;
        if ({fld, sts} !== {NOP_FLD, 4'b0001, 8'h02, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL restart_after_reset got=%h exp=%h", {fld, sts},
                     {NOP_FLD, 4'b0001, 8'h02, 1'b0, 1'b1, 1'b0, 1'b0});
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_early_fetch();
        test_cb_prefix();
        test_cb_table_cb();
        test_stall();
        test_saturate();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
